// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to transmitter and
// receiver), frame constants and a parity helper.
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int DEFAULT_OVERSAMPLE = 16;

  // Encodings are fixed so the transmitter and receiver decode states identically.
  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    START  = 3'b001,
    DATA   = 3'b010,
    PARITY = 3'b011,
    STOP   = 3'b100
  } uart_state_t;

  // Even parity over a data word; matches the transmitter's ^data.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input. RESET_VAL sets the
// value both flops take while reset is asserted (idle level of the input).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two back-to-back flops give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RESET_VAL;
      sync_reg <= RESET_VAL;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Oversamples rx with os_tick, detects the start edge and samples each bit
// at mid-bit. Optional parity bit is enabled with macro UART_RX_PARITY_EN;
// without it the frame is start + 8 data + stop and parity_err stays 0.
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 os_tick,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int            TW        = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);

  logic                 rx_sync;
  logic                 rx_hist_reg;
  uart_state_t          state_reg;
  uart_state_t          state_next;
  logic [TW-1:0]        tick_cnt_reg;
  logic [2:0]           bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic                 valid_reg;
  logic                 frame_err_reg;

  logic at_half;
  logic at_full;
  logic start_edge;
  logic shift_en;
  logic stop_sample;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_sync)
  );

  assign at_half    = os_tick && (tick_cnt_reg == HALF_LAST);
  assign at_full    = os_tick && (tick_cnt_reg == FULL_LAST);
  assign start_edge = os_tick && rx_hist_reg && !rx_sync;

  // Edge history follows the synchronized line once per oversample tick, so a
  // falling edge is seen on the first tick after it and a held-low line never re-triggers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_hist_reg <= 1'b1;
    end else if (os_tick) begin
      rx_hist_reg <= rx_sync;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; every transition is qualified by os_tick through the strobes.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (start_edge) state_next = START;
      START:  if (at_half)    state_next = rx_sync ? IDLE : DATA;
      DATA: begin
        if (at_full && (bit_cnt_reg == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (at_full) state_next = STOP;
`endif
      STOP:   if (at_full) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: busy and the per-bit sampling strobes.
  always_comb begin
    busy        = (state_reg != IDLE);
    shift_en    = (state_reg == DATA) && at_full;
    stop_sample = (state_reg == STOP) && at_full;
  end

  // Tick and bit counters; the tick counter restarts at each state change and
  // at every full bit period, which keeps the mid-bit alignment found in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
    end else if (os_tick) begin
      if ((state_reg == IDLE) || at_full || (state_next != state_reg)) begin
        tick_cnt_reg <= '0;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end
      if ((state_reg == IDLE) || (state_reg == START)) begin
        bit_cnt_reg <= '0;
      end else if (shift_en) begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
      end
    end
  end

  // Data bits arrive LSB first, so shift in from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {rx_sync, shift_reg[DATA_BITS-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_sample;
  logic par_err_pend_reg;
  logic parity_err_reg;

  assign par_sample = (state_reg == PARITY) && at_full;

  // Parity verdict is held until the stop bit so all flags update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_pend_reg <= 1'b0;
    end else if (par_sample) begin
      par_err_pend_reg <= rx_sync ^ even_parity(shift_reg);
    end
  end

  // Parity flag publishes with the byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_reg <= 1'b0;
    end else if (stop_sample) begin
      parity_err_reg <= par_err_pend_reg;
    end
  end

  assign parity_err = parity_err_reg;
`else
  assign parity_err = 1'b0;
`endif

  // Byte and framing flag publish on the stop-bit sample; valid pulses once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_reg      <= '0;
      frame_err_reg <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      valid_reg <= stop_sample;
      if (stop_sample) begin
        data_reg      <= shift_reg;
        frame_err_reg <= ~rx_sync;
      end
    end
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign frame_err = frame_err_reg;

endmodule
